// File: rtl/i3c_phy_filtered.sv
// I3C PHY front-end: N-stage synchroniser, programmable spike filter, edge / START / STOP
// strobes and bus-free detection on SCL/SDA. The pad output path is a pass-through.
module i3c_phy_filtered #(
    parameter int unsigned SyncStages  = 2,
    parameter int unsigned FilterWidth = 4,
    parameter int unsigned IdleWidth   = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic                   scl_o,
    output logic                   sda_o,
    input  logic                   ctrl_scl_i,
    input  logic                   ctrl_sda_i,
    output logic                   ctrl_scl_o,
    output logic                   ctrl_sda_o,
    input  logic                   sel_od_pp_i,
    output logic                   sel_od_pp_o,
    input  logic                   filt_en_i,
    input  logic [FilterWidth-1:0] filt_thr_i,
    input  logic [IdleWidth-1:0]   idle_thr_i,
    output logic                   scl_rise_o,
    output logic                   scl_fall_o,
    output logic                   sda_rise_o,
    output logic                   sda_fall_o,
    output logic                   start_det_o,
    output logic                   stop_det_o,
    output logic                   bus_free_o
);

    // Index 0 is SCL, index 1 is SDA throughout.
    logic [SyncStages-1:0]  r_scl_sync;
    logic [SyncStages-1:0]  r_sda_sync;
    logic [1:0]             w_sync;
    logic [FilterWidth-1:0] w_thr;
    logic [FilterWidth-1:0] r_cnt [2];
    logic [FilterWidth:0]   w_cnt_inc [2];
    logic [1:0]             r_filt;
    logic [1:0]             r_prev;
    logic [1:0]             w_rise;
    logic [1:0]             w_fall;
    logic                   w_scl_high;
    logic [1:0]             r_rise;
    logic [1:0]             r_fall;
    logic                   r_start;
    logic                   r_stop;
    logic                   w_any_edge;
    logic                   w_lines_high;
    logic [IdleWidth-1:0]   r_idle_cnt;
    logic                   r_bus_free;

    // Synchroniser shift chains, idle-high on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SyncStages-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SyncStages-2:0], sda_i};
        end
    end

    assign w_sync = {r_sda_sync[SyncStages-1], r_scl_sync[SyncStages-1]};

    // A zero or disabled threshold degenerates to accepting a level after one cycle.
    assign w_thr = (filt_en_i && (filt_thr_i != '0)) ? filt_thr_i : FilterWidth'(1);

    // Extended by one bit so the compare against the live threshold cannot wrap.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_cnt_inc[i] = {1'b0, r_cnt[i]} + (FilterWidth + 1)'(1);
        end
    end

    // Spike filter: accept a new level after w_thr consecutive mismatching cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_filt   <= '1;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_cnt_inc[i] >= {1'b0, w_thr}) begin
                    r_filt[i] <= w_sync[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= w_cnt_inc[i][FilterWidth-1:0];
                end
            end
        end
    end

    assign w_rise     = r_filt & ~r_prev;
    assign w_fall     = ~r_filt & r_prev;
    // SCL must be stable high; a simultaneous SCL change suppresses START/STOP.
    assign w_scl_high = r_filt[0] & r_prev[0];

    // Registered single-cycle edge and START/STOP strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prev  <= '1;
            r_rise  <= '0;
            r_fall  <= '0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
        end else begin
            r_prev  <= r_filt;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
            r_start <= w_fall[1] & w_scl_high;
            r_stop  <= w_rise[1] & w_scl_high;
        end
    end

    assign w_any_edge   = |(r_filt ^ r_prev);
    assign w_lines_high = &r_filt;

    // Bus-free: saturating count of quiet cycles with both lines high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idle_cnt <= '0;
            r_bus_free <= 1'b0;
        end else if (w_any_edge || !w_lines_high) begin
            r_idle_cnt <= '0;
            r_bus_free <= 1'b0;
        end else begin
            if (r_idle_cnt != '1) begin
                r_idle_cnt <= r_idle_cnt + IdleWidth'(1);
            end
            r_bus_free <= (r_idle_cnt >= idle_thr_i);
        end
    end

    assign scl_o       = ctrl_scl_i;
    assign sda_o       = ctrl_sda_i;
    assign sel_od_pp_o = sel_od_pp_i;
    assign ctrl_scl_o  = r_filt[0];
    assign ctrl_sda_o  = r_filt[1];
    assign scl_rise_o  = r_rise[0];
    assign scl_fall_o  = r_fall[0];
    assign sda_rise_o  = r_rise[1];
    assign sda_fall_o  = r_fall[1];
    assign start_det_o = r_start;
    assign stop_det_o  = r_stop;
    assign bus_free_o  = r_bus_free;

endmodule
